// File: rtl/pipe_line_div_pkg.sv
// Shared types and sizing for the pipelined signed divider.
package mini_core_accel_pkg;

  localparam int DIV_WIDTH   = 8;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

  // One pipeline slot: control flags plus the restoring-division working set.
  typedef struct packed {
    logic                 valid;
    logic                 neg_q;
    logic                 neg_r;
    logic                 div_zero;
    logic                 overflow;
    logic [DIV_WIDTH-1:0] dividend_orig;
    logic [DIV_WIDTH-1:0] divisor_abs;
    logic [DIV_WIDTH:0]   partial_rem;
    logic [DIV_WIDTH-1:0] quo_acc;
    logic [DIV_WIDTH-1:0] dividend_shift;
  } t_div_stage;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] v);
    return v[DIV_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/pipe_line_div_if.sv
// Start/ready handshake bundle shared with the pipelined multiplier.
interface pipe_line_div_if;
  import mini_core_accel_pkg::*;

  logic                 start;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 ready;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;

  modport master (output start, dividend, divisor, input ready, quotient, remainder);
  modport slave  (input start, dividend, divisor, output ready, quotient, remainder);
endinterface

// File: rtl/pipe_line_div_stage.sv
// One restoring-division iteration followed by its pipeline register.
module div_stage
  import mini_core_accel_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  t_div_stage stage_i,
  output t_div_stage stage_o
);

  t_div_stage           stage_d;
  t_div_stage           stage_q;
  logic [DIV_WIDTH:0]   rem_shift;
  logic [DIV_WIDTH+1:0] trial;

  // Shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    stage_d   = stage_i;
    rem_shift = {stage_i.partial_rem[DIV_WIDTH-1:0], stage_i.dividend_shift[DIV_WIDTH-1]};
    // One extra bit so the borrow is unambiguous for any remainder/divisor pair.
    trial     = {1'b0, rem_shift} - {2'b00, stage_i.divisor_abs};
    if (!trial[DIV_WIDTH+1]) begin
      stage_d.partial_rem = trial[DIV_WIDTH:0];
      stage_d.quo_acc     = {stage_i.quo_acc[DIV_WIDTH-2:0], 1'b1};
    end else begin
      stage_d.partial_rem = rem_shift;
      stage_d.quo_acc     = {stage_i.quo_acc[DIV_WIDTH-2:0], 1'b0};
    end
    stage_d.dividend_shift = {stage_i.dividend_shift[DIV_WIDTH-2:0], 1'b0};
    // Bubbles travel as all-zero slots.
    if (!stage_i.valid) begin
      stage_d = '0;
    end
  end

  // Pipeline register for this iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/pipe_line_div.sv
// Pipelined signed divider: input capture, WIDTH restoring stages, sign fix-up.
module pipe_line_div
  import mini_core_accel_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  pipe_line_div_if.slave bus
);

  localparam int WIDTH = DIV_WIDTH;

  t_div_stage       in_d;
  t_div_stage       in_q;
  t_div_stage       chain [0:WIDTH];
  t_div_stage       last;
  logic [WIDTH-1:0] quo_mag;
  logic [WIDTH-1:0] rem_mag;
  logic             ready_d, ready_q;
  logic [WIDTH-1:0] quotient_d, quotient_q;
  logic [WIDTH-1:0] remainder_d, remainder_q;

  // Capture operands as magnitudes plus the sign and special-case flags.
  always_comb begin
    in_d = '0;
    if (bus.start) begin
      in_d.valid          = 1'b1;
      in_d.neg_q          = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      in_d.neg_r          = bus.dividend[WIDTH-1];
      in_d.div_zero       = (bus.divisor == '0);
      in_d.overflow       = (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.divisor == '1);
      in_d.dividend_orig  = bus.dividend;
      in_d.divisor_abs    = div_abs(bus.divisor);
      in_d.dividend_shift = div_abs(bus.dividend);
    end
  end

  // Input register (stage 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= '0;
    end else begin
      in_q <= in_d;
    end
  end

  assign chain[0] = in_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    div_stage u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .stage_i (chain[gi]),
      .stage_o (chain[gi+1])
    );
  end

  assign last    = chain[WIDTH];
  assign quo_mag = last.quo_acc;
  assign rem_mag = last.partial_rem[WIDTH-1:0];

  // Restore signs, apply special cases, hold results between valid slots.
  always_comb begin
    ready_d     = last.valid;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    if (last.valid) begin
      quotient_d  = last.neg_q ? (~quo_mag + 1'b1) : quo_mag;
      remainder_d = last.neg_r ? (~rem_mag + 1'b1) : rem_mag;
      if (last.div_zero) begin
        quotient_d  = '1;
        remainder_d = last.dividend_orig;
      end else if (last.overflow) begin
        quotient_d  = {1'b1, {(WIDTH-1){1'b0}}};
        remainder_d = '0;
      end
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      ready_q     <= ready_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_pipe_line_div.sv
// Directed and random checks for the pipelined signed divider.
module tb_pipe_line_div;
  import mini_core_accel_pkg::*;

  localparam int W    = DIV_WIDTH;
  localparam int LAT  = DIV_LATENCY;
  localparam int MAXC = 2048;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_line_div_if bus ();

  pipe_line_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  logic         st_s  [MAXC];
  logic [W-1:0] st_a  [MAXC];
  logic [W-1:0] st_b  [MAXC];
  logic         obs_rdy [MAXC];
  logic [W-1:0] obs_q [MAXC];
  logic [W-1:0] obs_r [MAXC];
  logic [W-1:0] last_q, last_r;

  // Truncating reference division with the divide-by-zero and overflow rules.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    int ai, bi;
    ai = $signed(a);
    bi = $signed(b);
    if (bi == 0) begin
      q = '1;
      r = a;
    end else if (ai == -(1 << (W - 1)) && bi == -1) begin
      q = 8'h80;
      r = '0;
    end else begin
      q = W'(ai / bi);
      r = W'(ai % bi);
    end
  endfunction

  // Drive st_* for n cycles, then idle; record outputs at every falling edge.
  task automatic run_cycles(input int n);
    for (int t = 0; t < n + LAT + 2; t++) begin
      @(negedge clk);
      obs_rdy[t] = bus.ready;
      obs_q[t]   = bus.quotient;
      obs_r[t]   = bus.remainder;
      if (t < n) begin
        bus.start    = st_s[t];
        bus.dividend = st_a[t];
        bus.divisor  = st_b[t];
      end else begin
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    int pulses;
    rst_n        = 1'b0;
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    repeat (3) @(negedge clk);
    checks++; if (bus.ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.ready); else passed++;
    checks++; if (bus.quotient !== 8'h00) $display("FAIL reset_quotient got %h want 00", bus.quotient); else passed++;
    checks++; if (bus.remainder !== 8'h00) $display("FAIL reset_remainder got %h want 00", bus.remainder); else passed++;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    pulses    = 0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (bus.ready) pulses++;
    end
    checks++; if (pulses != 0) $display("FAIL reset_start_ignored got %0d pulses want 0", pulses); else passed++;
    last_q = '0;
    last_r = '0;
  endtask

  task automatic test_basic();
    st_s[0] = 1'b1; st_a[0] = 8'd100; st_b[0] = 8'd7;
    run_cycles(1);
    for (int t = 0; t < 1 + LAT + 2; t++) begin
      logic exp_rdy;
      exp_rdy = (t == LAT);
      if (exp_rdy) begin last_q = 8'd14; last_r = 8'd2; end
      checks++; if (obs_rdy[t] !== exp_rdy) $display("FAIL basic_ready t=%0d got %b want %b", t, obs_rdy[t], exp_rdy); else passed++;
      checks++; if (obs_q[t] !== last_q || obs_r[t] !== last_r)
        $display("FAIL basic_result t=%0d got q=%h r=%h want q=%h r=%h", t, obs_q[t], obs_r[t], last_q, last_r); else passed++;
    end
  endtask

  task automatic test_signs();
    logic [W-1:0] eq [4];
    logic [W-1:0] er [4];
    st_s[0] = 1'b1; st_a[0] = -8'd100; st_b[0] = 8'd7;
    st_s[1] = 1'b1; st_a[1] = 8'd100;  st_b[1] = -8'd7;
    st_s[2] = 1'b1; st_a[2] = -8'd100; st_b[2] = -8'd7;
    st_s[3] = 1'b1; st_a[3] = 8'h80;   st_b[3] = 8'd1;
    eq = '{8'hF2, 8'hF2, 8'h0E, 8'h80};
    er = '{8'hFE, 8'h02, 8'hFE, 8'h00};
    run_cycles(4);
    for (int t = 0; t < 4 + LAT + 2; t++) begin
      int   idx;
      logic exp_rdy;
      idx     = t - LAT;
      exp_rdy = (idx >= 0 && idx < 4);
      if (exp_rdy) begin last_q = eq[idx]; last_r = er[idx]; end
      checks++; if (obs_rdy[t] !== exp_rdy) $display("FAIL signs_ready t=%0d got %b want %b", t, obs_rdy[t], exp_rdy); else passed++;
      checks++; if (obs_q[t] !== last_q || obs_r[t] !== last_r)
        $display("FAIL signs_result t=%0d got q=%h r=%h want q=%h r=%h", t, obs_q[t], obs_r[t], last_q, last_r); else passed++;
    end
  endtask

  task automatic test_specials();
    logic [W-1:0] eq [3];
    logic [W-1:0] er [3];
    st_s[0] = 1'b1; st_a[0] = 8'd5;  st_b[0] = 8'd0;
    st_s[1] = 1'b1; st_a[1] = 8'h80; st_b[1] = 8'hFF;
    st_s[2] = 1'b1; st_a[2] = 8'd0;  st_b[2] = -8'd3;
    eq = '{8'hFF, 8'h80, 8'h00};
    er = '{8'h05, 8'h00, 8'h00};
    run_cycles(3);
    for (int t = 0; t < 3 + LAT + 2; t++) begin
      int   idx;
      logic exp_rdy;
      idx     = t - LAT;
      exp_rdy = (idx >= 0 && idx < 3);
      if (exp_rdy) begin last_q = eq[idx]; last_r = er[idx]; end
      checks++; if (obs_rdy[t] !== exp_rdy) $display("FAIL specials_ready t=%0d got %b want %b", t, obs_rdy[t], exp_rdy); else passed++;
      checks++; if (obs_q[t] !== last_q || obs_r[t] !== last_r)
        $display("FAIL specials_result t=%0d got q=%h r=%h want q=%h r=%h", t, obs_q[t], obs_r[t], last_q, last_r); else passed++;
    end
  endtask

  task automatic test_bubbles();
    logic pat [6];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      st_s[i] = pat[i];
      st_a[i] = W'(37 * i - 90);
      st_b[i] = W'(i - 3);
    end
    run_cycles(6);
    for (int t = 0; t < 6 + LAT + 2; t++) begin
      int   idx;
      logic exp_rdy;
      idx     = t - LAT;
      exp_rdy = (idx >= 0 && idx < 6) ? st_s[idx] : 1'b0;
      if (exp_rdy) ref_div(st_a[idx], st_b[idx], last_q, last_r);
      checks++; if (obs_rdy[t] !== exp_rdy) $display("FAIL bubbles_ready t=%0d got %b want %b", t, obs_rdy[t], exp_rdy); else passed++;
      checks++; if (obs_q[t] !== last_q || obs_r[t] !== last_r)
        $display("FAIL bubbles_result t=%0d got q=%h r=%h want q=%h r=%h", t, obs_q[t], obs_r[t], last_q, last_r); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = W'(50 + 20 * i);
      bus.divisor  = W'(3 + i);
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b0;
    #1;
    checks++; if (bus.ready !== 1'b0) $display("FAIL midreset_ready got %b want 0", bus.ready); else passed++;
    checks++; if (bus.quotient !== 8'h00) $display("FAIL midreset_quotient got %h want 00", bus.quotient); else passed++;
    checks++; if (bus.remainder !== 8'h00) $display("FAIL midreset_remainder got %h want 00", bus.remainder); else passed++;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    last_q = '0;
    last_r = '0;
    pulses = 0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (bus.ready) pulses++;
    end
    checks++; if (pulses != 0) $display("FAIL midreset_ghost got %0d pulses want 0", pulses); else passed++;
    st_s[0] = 1'b1; st_a[0] = 8'd9; st_b[0] = 8'd2;
    run_cycles(1);
    for (int t = 0; t < 1 + LAT + 2; t++) begin
      logic exp_rdy;
      exp_rdy = (t == LAT);
      if (exp_rdy) begin last_q = 8'd4; last_r = 8'd1; end
      checks++; if (obs_rdy[t] !== exp_rdy) $display("FAIL postreset_ready t=%0d got %b want %b", t, obs_rdy[t], exp_rdy); else passed++;
      checks++; if (obs_q[t] !== last_q || obs_r[t] !== last_r)
        $display("FAIL postreset_result t=%0d got q=%h r=%h want q=%h r=%h", t, obs_q[t], obs_r[t], last_q, last_r); else passed++;
    end
  endtask

  task automatic test_random();
    int n, issued, seen;
    n      = 0;
    issued = 0;
    while (issued < 1000 && n < MAXC - LAT - 4) begin
      st_s[n] = ($urandom_range(0, 3) != 0);
      st_a[n] = ($urandom_range(0, 15) == 0) ? 8'h80 : W'($urandom);
      case ($urandom_range(0, 15))
        0:       st_b[n] = 8'h00;
        1:       st_b[n] = 8'hFF;
        default: st_b[n] = W'($urandom);
      endcase
      if (st_s[n]) issued++;
      n++;
    end
    run_cycles(n);
    seen = 0;
    for (int t = 0; t < n + LAT + 2; t++) begin
      int   idx;
      logic exp_rdy;
      idx     = t - LAT;
      exp_rdy = (idx >= 0 && idx < n) ? st_s[idx] : 1'b0;
      if (exp_rdy) ref_div(st_a[idx], st_b[idx], last_q, last_r);
      if (obs_rdy[t] === 1'b1) seen++;
      checks++; if (obs_rdy[t] !== exp_rdy) $display("FAIL random_ready t=%0d got %b want %b", t, obs_rdy[t], exp_rdy); else passed++;
      checks++; if (obs_q[t] !== last_q || obs_r[t] !== last_r)
        $display("FAIL random_result t=%0d got q=%h r=%h want q=%h r=%h", t, obs_q[t], obs_r[t], last_q, last_r); else passed++;
    end
    checks++; if (seen != issued) $display("FAIL random_count got %0d ready pulses want %0d", seen, issued); else passed++;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    last_q       = '0;
    last_r       = '0;
    test_reset();
    test_basic();
    test_signs();
    test_specials();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_line_div.md
# pipe_line_div

Pipelined signed integer divider for the mini_core_accel accelerator, the inverse of the pipelined multiplier. It accepts one dividend/divisor pair per cycle on a start strobe and returns quotient and remainder after a fixed latency with a one-cycle ready pulse. There is no backpressure, and results leave in issue order. It sits beside the multiplier in the accelerator datapath and uses the same start/ready handshake.

## Interface
- WIDTH, 8, operand and result width in bits; all values are two's-complement signed.
- LATENCY, WIDTH+2, cycles from start to ready; derived, not overridable.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  operands valid this cycle; sampled every rising edge.
- dividend  in  WIDTH  signed dividend.
- divisor  in  WIDTH  signed divisor.
- ready  out  1  one-cycle pulse; quotient/remainder valid this cycle.
- quotient  out  WIDTH  signed quotient, truncated toward zero.
- remainder  out  WIDTH  signed remainder; its sign follows the dividend.

## Operation
- Stage 0 (input register):
  - Captures start as the valid bit, |dividend|, |divisor|, neg_q = sign(dividend) XOR sign(divisor), neg_r = sign(dividend).
  - Flags div_zero (divisor==0) and overflow (dividend==-2^(WIDTH-1) and divisor==-1).
- Stages 1..WIDTH: one restoring-division iteration per stage, producing one quotient bit MSB-first.
  - Partial remainder is WIDTH+1 bits; shift left, bring in the next dividend bit, trial-subtract |divisor|.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0.
  - Magnitude of -2^(WIDTH-1) is handled as the unsigned value 2^(WIDTH-1).
- Output stage:
  - Negates quotient if neg_q and remainder if neg_r.
  - Applies the special cases, which override the arithmetic result:
    - div_zero: quotient = all ones (-1), remainder = dividend.
    - overflow: quotient = -2^(WIDTH-1), remainder = 0.
- Every stage carries its own valid bit plus sign and special flags. Invalid stages propagate valid=0.
- Throughput is one operation per cycle. start=0 inserts a bubble, which reappears as ready=0 exactly LATENCY cycles later.
- quotient/remainder update only when the output stage is valid and hold the last result otherwise.

## Timing
- Operation sampled with start=1 at rising edge k: ready=1 and results valid during the cycle after edge k+LATENCY-1 (10 cycles for WIDTH=8). ready drops the following cycle unless the next slot is valid.
- N consecutive start cycles produce N consecutive ready cycles in the same order.
- Reset values while rst_n=0: ready=0, quotient=0, remainder=0, all stage valid bits 0, all stage data 0.
- Reset mid-operation:
  - In-flight operations are discarded immediately (asynchronous).
  - No ready pulse ever appears for them after rst_n deasserts.
  - The first start sampled after release completes normally with full latency.
- start is ignored while rst_n=0.
- Operand X/garbage while start=0 has no observable effect on ready or outputs.

## Structure
- mini_core_accel_pkg holds:
  - DIV_WIDTH = 8 and DIV_LATENCY = DIV_WIDTH+2.
  - typedef t_div_stage: valid, neg_q, neg_r, div_zero, overflow, dividend_orig, divisor_abs, partial_rem, quo_acc, dividend_shift.
- One sub-module, div_stage:
  - Combinational single restoring iteration plus its pipeline register on t_div_stage, with asynchronous active-low reset.
  - Instantiated WIDTH times in a generate loop.
- Top level pipe_line_div contains the input stage, the generate chain and the output sign/special-case stage.

## Test plan
- Basic: 100 / 7 with a single start pulse -> exactly one ready pulse 10 cycles later; quotient=14, remainder=2; outputs hold afterwards.
- Signs, four back-to-back cycles of (-100,7), (100,-7), (-100,-7), (-128,1) -> four consecutive ready cycles:
  - (-14,-2)
  - (-14,2)
  - (14,-2)
  - (-128,0)
- Specials: 5 / 0 -> quotient=8'hFF, remainder=5; -128 / -1 -> quotient=-128, remainder=0; 0 / -3 -> quotient=0, remainder=0.
- Bubbles: start pattern 1,0,1,1,0,1 with distinct operands -> ready pattern 1,0,1,1,0,1 starting 10 cycles later, each result matching a reference model.
- Reset mid-flight: issue 3 operations, then drive rst_n=0 for 2 cycles at the 4th cycle -> ready, quotient and remainder read 0 immediately, and no ready pulse follows. A post-reset 9 / 2 returns (4,1) 10 cycles after its start.
- Random: 1000 random operand pairs with random start density -> every result matches the truncating reference model, with no missing or extra ready pulses.
